// File: rtl/pps_div_cfg_sequencer_if.sv
// Register-bus connection between the divider config sequencer and the shared bus/arbiter.
// Signal names keep the sequencer-side direction prefix on both modports.
interface pps_div_cfg_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  o_bus_req;
   logic                  i_bus_gnt;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_wr;
   logic [DATA_WIDTH-1:0] i_rdata;

   modport master (
      output o_bus_req, o_addr, o_data, o_wr,
      input  i_bus_gnt, i_rdata
   );

   modport slave (
      input  o_bus_req, o_addr, o_data, o_wr,
      output i_bus_gnt, i_rdata
   );
endinterface

// File: rtl/pps_div_cfg_sequencer.sv
// Snapshots one pps divider configuration and writes its nine registers over the shared bus,
// optionally reading them back and latching the offset of the first mismatch.
module pps_div_cfg_sequencer #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   // Address of PPS_DIV_0_PER_TRUE in the target bank
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'('h10)
) (
   input  logic                    i_clk_10,
   input  logic                    i_rst_n,
   input  logic                    i_load,
   input  logic                    i_verify_en,
   input  logic [DATA_WIDTH-1:0]   i_periodic_true,
   input  logic [DATA_WIDTH-1:0]   i_div_number,
   input  logic [4*DATA_WIDTH-1:0] i_phase_us,
   input  logic [DATA_WIDTH-1:0]   i_width_us,
   input  logic [DATA_WIDTH-1:0]   i_start,
   input  logic [DATA_WIDTH-1:0]   i_stop,
   pps_div_cfg_sequencer_if.master bus,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic [3:0]              o_err_idx
);

   localparam int NREG = 9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_VERIFY,
      S_CHECK
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shadow_q [NREG];
   logic                  verify_q;
   logic                  rd_pend_q;
   logic [3:0]            rd_idx_q;
   logic                  err_q;
   logic [3:0]            err_idx_q;
   logic                  done_q, done_d;

   logic                  load_acc;
   logic                  last_idx;
   logic                  rd_mismatch;

   // A load coinciding with the completion pulse is dropped so o_err stays readable that cycle
   assign load_acc    = (state_q == S_IDLE) && i_load && !done_q;
   assign last_idx    = (idx_q == 4'd8);
   assign rd_mismatch = rd_pend_q && (bus.i_rdata != shadow_q[rd_idx_q]);
   assign done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);

   always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (load_acc) begin
               state_d = S_WRITE;
               idx_d   = '0;
            end
         end
         S_WRITE: begin
            if (bus.i_bus_gnt) begin
               if (last_idx) begin
                  state_d = verify_q ? S_VERIFY : S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_VERIFY: begin
            if (bus.i_bus_gnt) begin
               if (last_idx) begin
                  state_d = S_CHECK;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_CHECK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_bus_req = 1'b0;
      bus.o_wr      = 1'b0;
      bus.o_addr    = '0;
      bus.o_data    = '0;
      o_busy        = 1'b0;
      unique case (state_q)
         S_IDLE: ;
         S_WRITE: begin
            bus.o_bus_req = 1'b1;
            bus.o_wr      = bus.i_bus_gnt;
            bus.o_addr    = BASE_ADDR + ADDR_WIDTH'(idx_q);
            bus.o_data    = shadow_q[idx_q];
            o_busy        = 1'b1;
         end
         S_VERIFY: begin
            bus.o_bus_req = 1'b1;
            bus.o_addr    = BASE_ADDR + ADDR_WIDTH'(idx_q);
            o_busy        = 1'b1;
         end
         S_CHECK: o_busy = 1'b1;
         default: ;
      endcase
   end

   // Shadow copy, readback tracking and sticky error capture
   always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NREG; k++) shadow_q[k] <= '0;
         verify_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= '0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= done_d;
         rd_pend_q <= (state_q == S_VERIFY) && bus.i_bus_gnt;
         if ((state_q == S_VERIFY) && bus.i_bus_gnt) rd_idx_q <= idx_q;
         if (load_acc) begin
            shadow_q[0] <= i_periodic_true;
            shadow_q[1] <= i_div_number;
            for (int k = 0; k < 4; k++) shadow_q[2+k] <= i_phase_us[k*DATA_WIDTH +: DATA_WIDTH];
            shadow_q[6] <= i_width_us;
            shadow_q[7] <= i_start;
            shadow_q[8] <= i_stop;
            verify_q    <= i_verify_en;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
         end else if (rd_mismatch && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= rd_idx_q;
         end
      end
   end

   assign o_done    = done_q;
   assign o_err     = err_q;
   assign o_err_idx = err_idx_q;

endmodule

// File: tb/tb_pps_div_cfg_sequencer.sv
// Directed and randomized bench for pps_div_cfg_sequencer against a cycle-counting reference model
// and a register-bank bus responder with optional readback corruption.
module tb_pps_div_cfg_sequencer;

   localparam logic [7:0] BASE = 8'h10;
   localparam int         MAXC = 75;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load, verify_en;
   logic [7:0]  per, div, width, start, stop;
   logic [31:0] phase;
   logic        busy, done, err;
   logic [3:0]  err_idx;

   logic [7:0]  cfg_b [9];
   bit          gnt_pat [80];
   bit          corrupt [256];
   logic [7:0]  mem [256] = '{default: 8'h00};
   int          checks, errors;

   pps_div_cfg_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   pps_div_cfg_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(BASE)) dut (
      .i_clk_10        (clk),
      .i_rst_n         (rst_n),
      .i_load          (load),
      .i_verify_en     (verify_en),
      .i_periodic_true (per),
      .i_div_number    (div),
      .i_phase_us      (phase),
      .i_width_us      (width),
      .i_start         (start),
      .i_stop          (stop),
      .bus             (bus),
      .o_busy          (busy),
      .o_done          (done),
      .o_err           (err),
      .o_err_idx       (err_idx)
   );

   always #50 clk = ~clk;

   // Divider register bank: write on strobe, read data one cycle after the address
   always @(posedge clk) begin
      if (bus.o_wr) mem[bus.o_addr] <= bus.o_data;
      bus.i_rdata <= corrupt[bus.o_addr] ? 8'hFF : mem[bus.o_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {bus.o_bus_req, bus.o_wr, busy, done, err, err_idx, bus.o_addr, bus.o_data}, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_cfg();
      per   = cfg_b[0];
      div   = cfg_b[1];
      phase = {cfg_b[5], cfg_b[4], cfg_b[3], cfg_b[2]};
      width = cfg_b[6];
      start = cfg_b[7];
      stop  = cfg_b[8];
   endtask

   task automatic scramble_inputs();
      per = 8'($urandom); div = 8'($urandom); phase = $urandom;
      width = 8'($urandom); start = 8'($urandom); stop = 8'($urandom);
      verify_en = 1'($urandom_range(0, 1));
   endtask

   task automatic rand_cfg();
      for (int j = 0; j < 9; j++) cfg_b[j] = 8'($urandom);
   endtask

   task automatic gnt_all();
      for (int j = 0; j < 80; j++) gnt_pat[j] = 1'b1;
   endtask

   task automatic gnt_rand();
      for (int j = 0; j < 80; j++) gnt_pat[j] = (j >= 40) || ($urandom_range(0, 3) != 0);
   endtask

   task automatic clear_corrupt();
      for (int j = 0; j < 256; j++) corrupt[j] = 1'b0;
   endtask

   // Entered just after a rising edge; cycle 0 is the cycle carrying the load pulse.
   // Returns just after the rising edge that follows the completion pulse.
   task automatic run_seq(input bit ver, input int busy_load_c, input bit load_on_done);
      int         wc [9];
      int         c, k, exp_done, last_acc, d, nw, exp_eidx;
      bit         exp_err;
      logic [7:0] rb;
      // Each register access consumes one granted cycle, starting in cycle 1
      c = 1; k = 0;
      while (k < 9) begin
         if (gnt_pat[c]) begin wc[k] = c; k++; end
         c++;
      end
      if (ver) begin
         k = 0;
         while (k < 9) begin
            if (gnt_pat[c]) k++;
            c++;
         end
         exp_done = c + 1;
      end else begin
         exp_done = c;
      end
      last_acc = c - 1;
      exp_err = 1'b0; exp_eidx = 0;
      if (ver) begin
         for (int j = 0; j < 9; j++) begin
            rb = corrupt[int'(BASE) + j] ? 8'hFF : cfg_b[j];
            if (rb !== cfg_b[j] && !exp_err) begin exp_err = 1'b1; exp_eidx = j; end
         end
      end
      apply_cfg();
      verify_en = ver;
      load = 1'b1;
      bus.i_bus_gnt = gnt_pat[0];
      nw = 0; d = -1;
      for (int cy = 0; cy < MAXC && d < 0; cy++) begin
         if (cy > 0) begin
            step();
            load = (cy == busy_load_c) || (load_on_done && cy == exp_done);
            bus.i_bus_gnt = gnt_pat[cy];
            if (cy == busy_load_c) scramble_inputs();
         end
         @(negedge clk);
         if (bus.o_wr) begin
            if (nw < 9) begin
               chk("wr_cycle", cy, wc[nw]);
               chk("wr_addr", bus.o_addr, int'(BASE) + nw);
               chk("wr_data", bus.o_data, cfg_b[nw]);
            end else begin
               chk("wr_count", nw + 1, 9);
            end
            nw++;
         end
         if (cy >= 1) chk("busy", busy, cy < exp_done);
         if (cy >= 1 && cy <= last_acc) chk("bus_req", bus.o_bus_req, 1);
         if (done) d = cy;
      end
      chk("done_cycle", d, exp_done);
      chk("n_writes", nw, 9);
      chk("err", err, exp_err);
      chk("err_idx", err_idx, exp_eidx);
      step();
      load = 1'b0;
      bus.i_bus_gnt = 1'b1;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; load = 1'b0; verify_en = 1'b0;
      per = '0; div = '0; phase = '0; width = '0; start = '0; stop = '0;
      bus.i_bus_gnt = 1'b0;
      clear_corrupt();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset_outputs");
      rst_n = 1'b1;
      step();

      // Basic write, verify off
      cfg_b = '{8'h01, 8'h05, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h20, 8'h02, 8'h30};
      gnt_all();
      run_seq(1'b0, -1, 1'b0);
      @(negedge clk);
      chk_zero("idle_after_done");
      step();

      // Verify pass, then mismatch on 0x14 and 0x17, then a clean run clears the flag
      run_seq(1'b1, -1, 1'b0);
      corrupt[8'h14] = 1'b1;
      corrupt[8'h17] = 1'b1;
      run_seq(1'b1, -1, 1'b0);
      clear_corrupt();
      rand_cfg();
      run_seq(1'b1, -1, 1'b0);

      // Grant withdrawn in cycles 3..5
      cfg_b = '{8'h01, 8'h05, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h20, 8'h02, 8'h30};
      gnt_all();
      gnt_pat[3] = 1'b0; gnt_pat[4] = 1'b0; gnt_pat[5] = 1'b0;
      run_seq(1'b0, -1, 1'b0);

      // Second load while busy is ignored
      gnt_all();
      rand_cfg();
      run_seq(1'b0, 4, 1'b0);

      // Load coinciding with completion is ignored
      rand_cfg();
      run_seq(1'b1, -1, 1'b1);
      @(negedge clk);
      chk("load_at_done_ignored", busy, 0);
      step();

      // Randomized configurations, grant patterns and readback corruption
      for (int it = 0; it < 8; it++) begin
         rand_cfg();
         gnt_rand();
         clear_corrupt();
         for (int n = 0; n < int'($urandom_range(0, 2)); n++)
            corrupt[int'(BASE) + int'($urandom_range(0, 8))] = 1'b1;
         run_seq(1'($urandom_range(0, 1)), -1, 1'b0);
      end
      clear_corrupt();
      gnt_all();

      // Reset asserted in cycle 5 of a burst
      rand_cfg();
      apply_cfg();
      verify_en = 1'b1;
      load = 1'b1;
      bus.i_bus_gnt = 1'b1;
      for (int cy = 1; cy <= 4; cy++) begin
         step();
         load = 1'b0;
      end
      step();
      rst_n = 1'b0;
      #1;
      chk_zero("reset_mid_burst");
      repeat (2) begin
         @(negedge clk);
         chk_zero("held_in_reset");
      end
      rst_n = 1'b1;
      step();
      rand_cfg();
      run_seq(1'b1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pps_div_cfg_sequencer.md
# pps_div_cfg_sequencer

Sequences a complete configuration of one pps divider register bank over the shared register bus. It snapshots a full divider configuration on a load pulse, then requests the bus and writes all nine divider registers in address order. Optionally it reads every register back and flags the first mismatch. It sits between the host/config logic and the register bus, alongside the SPI-driven register path, under an external bus arbiter.

## Interface
Parameters:
- ADDR_WIDTH, 8, register bus address width.
- DATA_WIDTH, 8, register bus data width.
- BASE_ADDR, PPS_DIV_0_PER_TRUE, address of offset 0 of the target divider bank.

Ports:
- i_clk_10  in  1  system clock, 10 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_load  in  1  start pulse; sampled only in IDLE.
- i_verify_en  in  1  sampled with i_load; enables readback.
- i_periodic_true  in  DATA_WIDTH  configuration value for offset 0.
- i_div_number  in  DATA_WIDTH  configuration value for offset 1.
- i_phase_us  in  4*DATA_WIDTH  configuration value for offsets 2..5.
- i_width_us  in  DATA_WIDTH  configuration value for offset 6.
- i_start  in  DATA_WIDTH  configuration value for offset 7.
- i_stop  in  DATA_WIDTH  configuration value for offset 8.
- o_bus_req  out  1  bus request to the arbiter.
- i_bus_gnt  in  1  bus grant from the arbiter.
- o_addr  out  ADDR_WIDTH  bus address, BASE_ADDR+idx.
- o_data  out  DATA_WIDTH  bus write data.
- o_wr  out  1  bus write strobe.
- i_rdata  in  DATA_WIDTH  bus read data; valid one cycle after its address is presented with o_wr=0.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  readback mismatch; sticky.
- o_err_idx  out  4  offset of the first mismatch.

## Operation
- Offset map from BASE_ADDR:
  - 0 per_true.
  - 1 div_num.
  - 2..5 phase bytes, LSB first: offset 2 = i_phase_us[7:0], offset 5 = MSB byte.
  - 6 width.
  - 7 start.
  - 8 stop.
- i_load in IDLE:
  - Snapshot all config inputs and i_verify_en into shadow registers; later input changes are ignored.
  - Clear o_err and o_err_idx; set idx=0.
  - Go to WRITE.
- i_load while not IDLE is ignored.
- States:
  - IDLE: o_bus_req=0, o_busy=0.
  - WRITE: o_bus_req=1. o_wr=i_bus_gnt (combinational). o_data=shadow[idx]. idx advances only on cycles with gnt=1. After idx=8 is written: go to VERIFY with idx=0 if verify is set, else go to IDLE.
  - VERIFY: o_bus_req=1, o_wr=0. An address is issued on cycles with gnt=1, which sets rd_pend with rd_idx=idx; idx then advances. Each cycle with rd_pend set, compare i_rdata against shadow[rd_idx]. After the address for idx=8 is issued, go to CHECK.
  - CHECK: final compare for offset 8; go to IDLE.
- Mismatch:
  - On the first mismatch: o_err=1, o_err_idx=rd_idx.
  - Later mismatches do not change o_err_idx.
  - The sequence always runs to completion.
- Grant withdrawn mid-sequence: o_bus_req stays 1, no write or read is issued, idx is held. A compare already pending still completes.
- o_addr and o_data are don't-care when o_wr=0 outside VERIFY. Drive them to 0 in IDLE.

## Timing
- Reset (async assert, sync release) values:
  - State IDLE.
  - o_bus_req, o_wr, o_busy, o_done, o_err = 0.
  - o_err_idx, o_addr, o_data = 0.
  - Shadow registers = 0.
- Reset mid-sequence aborts immediately; the target bank is left partially written.
- Reference timeline: i_load high in cycle 0, gnt held high.
  - Cycles 1..9: writes to offsets 0..8; o_busy=1 from cycle 1.
  - No verify: cycle 10 is IDLE; o_done=1 for one cycle, o_busy=0, o_bus_req=0.
  - Verify: read addresses in cycles 10..18, compares in cycles 11..19 (cycle 19 = CHECK). Cycle 20: o_done=1, o_busy=0.
- Each gnt-low cycle in WRITE or VERIFY extends completion by exactly one cycle.
- o_err and o_err_idx are valid when o_done is pulsed and hold until the next accepted i_load.
- i_load in the same cycle as o_done is ignored; i_load one cycle after o_done is accepted.

## Test plan
- Basic write: BASE_ADDR=0x10, config per=1, div=5, phase=0x0A0B0C0D, width=0x20, start=0x02, stop=0x30, verify off, gnt=1. Required: 9 writes in cycles 1..9 to 0x10..0x18, data 01,05,0D,0C,0B,0A,20,02,30; o_done in cycle 10.
- Verify pass: same config, bus model is the divider register bank, verify on. Required: o_done in cycle 20, o_err=0.
- Verify mismatch: bus model corrupts readback of 0x14 to 0xFF, and also 0x17. Required: o_err=1, o_err_idx=4, o_done in cycle 20.
- Grant stall: gnt low in cycles 3..5. Required: offsets 0..1 written in cycles 1..2, offset 2 written in cycle 6, o_done in cycle 13 (verify off); o_bus_req high throughout.
- Load while busy: second i_load with different config in cycle 4. Required: ignored; original data written; one o_done.
- Reset mid-burst: i_rst_n low in cycle 5. Required: all outputs 0 within the same cycle, no o_done; a fresh i_load after release runs a full sequence.
